fib_bin2bcd: RTL and testbench
==============================

// Module: fib_bin2bcd
// PURPOSE
//   Sequential binary-to-BCD converter (shift-and-add-3 / double dabble) placed
//   directly downstream of the Fibonacci engine. Accepts one N-bit binary result
//   per start/ready handshake and produces D packed BCD digits for display/UART
//   stages. One digit-adjust+shift iteration per clock; same IDLE/OP/DONE FSM
//   style and start/ready/done handshake as the generator it consumes from.
// PARAMETERS
//   N  21  binary input width; matches the Fibonacci output width (F(31)=1346269 < 2^21)
//   D   7  BCD digit count; legal only if 10^D > 2^N-1 (not checked in RTL)
// PORTS
//   clk    in   1    single clock, rising edge
//   rst    in   1    synchronous, active-high reset
//   start  in   1    request conversion; accepted only when ready=1
//   bin    in   N    binary value, sampled on the accepting edge only
//   ready  out  1    1 while FSM in IDLE (combinational from state)
//   done   out  1    1-cycle pulse; bcd valid in that same cycle
//   bcd    out  4*D  packed BCD; digit i = bcd[4i+3:4i]; digit 0 = units
// BEHAVIOUR
//   - Reset: state=IDLE, ready=1, done=0, bcd=0, internal shift/counter regs=0.
//     Reset mid-conversion aborts it: next cycle IDLE, bcd=0, no done pulse.
//   - States (one-hot, 3 bits): IDLE, OP, DONE.
//     IDLE: ready=1. start=1 -> load bin into shift reg, clear BCD work reg,
//       load counter with N, go OP. start=0 -> stay.
//     OP: ready=0. Each cycle: every work digit >=5 gets +3 (all digits in
//       parallel, adjusted before shift), then {work,shift} shifts left 1 with
//       the shift-reg MSB entering work digit 0 LSB; counter decrements. Exactly
//       N iterations. On the Nth iteration the post-shift work value is also
//       written to bcd; go DONE.
//     DONE: done=1, ready=0, go IDLE unconditionally.
//   - Timing: start sampled at edge k -> OP cycles k+1..k+N -> done=1 in cycle
//     k+N+1 -> ready=1 again in cycle k+N+2. Throughput 1 result per N+2 cycles.
//   - start while ready=0 (OP or DONE) is ignored; no queuing. bin changes after
//     acceptance have no effect.
//   - bcd holds the last completed result between conversions; changes only at
//     the DONE-entry edge or reset. Intermediate work values never reach bcd.
//   - Counter width $clog2(N+1); no wrap (leaves OP at count 1 -> 0).
//   - Digit adjust is 4-bit; with legal D no digit exceeds 9 after any shift,
//     and no bit is shifted out of the top digit.
//   - bin=0: still runs full N iterations; result 0.
// TESTING
//   1 rst 2 cycles, then idle -> ready=1, done=0, bcd=0 throughout.
//   2 bin=0, start 1 cycle -> done in cycle k+22, bcd=28'h0000000, ready=1 at k+23.
//   3 bin=55 (F(10)) -> bcd=28'h0000055; bin=1346269 (F(31)) -> 28'h1346269;
//     bin=2097151 (all ones) -> 28'h2097151; each with done exactly 1 cycle.
//   4 start held high continuously with bin stepping 9,10,99,100 -> one
//     conversion per 23 cycles, results 0x9,0x10,0x99,0x100; stray starts in OP/DONE ignored.
//   5 conversion of 1346269 completed, then new start with bin=987 and rst
//     asserted in 5th OP cycle -> next cycle IDLE, bcd=0, no done pulse.
//   6 chained with Fibonacci engine (fib->bin, its done->start), n=0..31 sweep
//     -> bcd equals decimal F(n) per golden model, e.g. n=20 -> 28'h0006765.

Source files
------------

// File: rtl/fib_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, "double dabble").
// Sits directly downstream of the Fibonacci engine and converts one N-bit
// result per start/ready handshake into D packed BCD digits, one
// adjust+shift iteration per clock.
module fib_bin2bcd #(
    parameter int N = 21,
    parameter int D = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   bin,
    output logic           ready,
    output logic           done,
    output logic [4*D-1:0] bcd
);

    localparam int CW = $clog2(N + 1);

    // One-hot state encoding keeps each state decode to a single flop bit.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        OP   = 3'b010,
        DONE = 3'b100
    } state_e;

    state_e         state_q;
    logic [N-1:0]   shift_q;
    logic [4*D-1:0] work_q;
    logic [4*D-1:0] bcd_q;
    logic [CW-1:0]  cnt_q;
    logic           done_q;

    logic [4*D-1:0] adj;
    logic [4*D-1:0] work_d;
    logic [N-1:0]   shift_d;

    // Add 3 to every work digit that is 5 or more, all digits in parallel,
    // so that the following left shift carries correctly into the next digit.
    always_comb begin
        adj = work_q;
        for (int i = 0; i < D; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Shift the adjusted work register and the binary shift register left as
    // one long register: the binary MSB enters the units digit LSB.
    always_comb begin
        work_d  = (adj << 1) | {{(4*D-1){1'b0}}, shift_q[N-1]};
        shift_d = shift_q << 1;
    end

    // Control FSM plus datapath registers; bcd is only written on the last
    // iteration so intermediate work values never become visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            work_q  <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        shift_q <= bin;
                        work_q  <= '0;
                        cnt_q   <= CW'(N);
                        state_q <= OP;
                    end
                end
                OP: begin
                    work_q  <= work_d;
                    shift_q <= shift_d;
                    cnt_q   <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        bcd_q   <= work_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = done_q;
    assign bcd   = bcd_q;

endmodule

// File: tb/tb_fib_bin2bcd.sv
// Self-checking bench for fib_bin2bcd: directed cases, randomized values and a
// Fibonacci sweep, checked by a queue-based scoreboard against a decimal model.
module tb_fib_bin2bcd;

    localparam int N = 21;
    localparam int D = 7;
    localparam int W = 4 * D;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] bin   = '0;
    logic         ready;
    logic         done;
    logic [W-1:0] bcd;

    fib_bin2bcd #(.N(N), .D(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .ready (ready),
        .done  (done),
        .bcd   (bcd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] val;
        int           cyc;
    } exp_t;

    exp_t         expQ[$];
    int           cyc           = 0;
    logic [W-1:0] modelBcd      = '0;
    int           checks        = 0;
    int           errors        = 0;
    int           acceptCount   = 0;
    int           lastAcceptCyc = 0;
    int           prevAcceptCyc = 0;

    // Decimal reference: peel off base-10 digits with plain arithmetic.
    function automatic logic [W-1:0] refBcd(input longint v);
        logic [W-1:0] r;
        longint       x;
        r = '0;
        x = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic longint fibRef(input int n);
        longint a, b, t;
        a = 0;
        b = 1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Acceptance observer: records every accepted request with its expected
    // result and the cycle in which done must appear; reset drops everything.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            expQ.delete();
            modelBcd = '0;
        end else begin
            if (expQ.size() > 0 && expQ[0].cyc == cyc) modelBcd = expQ[0].val;
            if (start && ready) begin
                expQ.push_back('{refBcd(longint'(bin)), cyc + N});
                acceptCount++;
                prevAcceptCyc = lastAcceptCyc;
                lastAcceptCyc = cyc;
            end
        end
    end

    // Monitor: on the falling edge compare done/ready/bcd with the scoreboard.
    always @(negedge clk) begin
        if (expQ.size() > 0 && cyc >= expQ[0].cyc) begin
            checkOutput("doneAtLatency", W'(done), W'(1'b1));
            checkOutput("resultBcd", bcd, expQ[0].val);
            checkOutput("readyInDone", W'(ready), W'(1'b0));
            void'(expQ.pop_front());
        end else begin
            checkOutput("noStrayDone", W'(done), W'(1'b0));
            checkOutput("readyState", W'(ready), W'(expQ.size() == 0));
            checkOutput("bcdHold", bcd, modelBcd);
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic waitReady();
        int budget;
        budget = 4 * (N + 2);
        while (!ready && budget > 0) begin
            stepCycle();
            budget--;
        end
        if (!ready) timeoutFail("waitReady");
    endtask

    task automatic waitDrain();
        int budget;
        budget = 4 * (N + 2);
        while ((expQ.size() != 0 || !ready) && budget > 0) begin
            stepCycle();
            budget--;
        end
        if (expQ.size() != 0 || !ready) timeoutFail("waitDrain");
    endtask

    // One start pulse with a value, then scramble bin to show it is not re-read.
    task automatic applyStimulus(input logic [N-1:0] v);
        waitReady();
        start = 1'b1;
        bin   = v;
        stepCycle();
        start = 1'b0;
        bin   = N'($urandom);
        waitDrain();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N-1:0] heldVals[4];
        int           seenAccepts;
        int           budget;

        heldVals[0] = N'(9);
        heldVals[1] = N'(10);
        heldVals[2] = N'(99);
        heldVals[3] = N'(100);

        // Reset for two cycles, then idle.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (5) stepCycle();

        // Zero and directed values.
        applyStimulus(N'(0));
        applyStimulus(N'(55));
        applyStimulus(N'(1346269));
        applyStimulus(N'(2097151));

        // start held high: one conversion per N+2 cycles, strays ignored.
        waitReady();
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bin = heldVals[i];
            seenAccepts = acceptCount;
            budget = 4 * (N + 2);
            while (acceptCount == seenAccepts && budget > 0) begin
                stepCycle();
                budget--;
            end
            if (acceptCount == seenAccepts) timeoutFail("heldAccept");
            else if (i > 0) checkOutput("acceptSpacing", W'(lastAcceptCyc - prevAcceptCyc), W'(N + 2));
        end
        start = 1'b0;
        waitDrain();

        // Reset in the 5th OP cycle of a conversion aborts it.
        applyStimulus(N'(1346269));
        waitReady();
        start = 1'b1;
        bin   = N'(987);
        stepCycle();
        start = 1'b0;
        repeat (4) stepCycle();
        rst = 1'b1;
        stepCycle();
        checkOutput("abortReady", W'(ready), W'(1'b1));
        checkOutput("abortDone", W'(done), W'(1'b0));
        checkOutput("abortBcd", bcd, W'(0));
        rst = 1'b0;
        repeat (3 * N) stepCycle();
        applyStimulus(N'(987));

        // Randomized values across the full input range.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(N'($urandom_range(0, (1 << N) - 1)));
        end

        // Fibonacci sweep as produced by the upstream engine.
        for (int n = 0; n <= 31; n++) begin
            applyStimulus(N'(fibRef(n)));
            if (n == 20) checkOutput("fib20Bcd", bcd, 28'h0006765);
        end

        waitDrain();
        repeat (3) stepCycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
